// File: rtl/prbs_checker.sv
// Purpose: serial checker for the 8-bit LFSR sequence (feedback r7^r5^r4^r3,
//          shift left, feedback into bit 0); hunts, confirms, locks, counts bit errors.
// Latency: all outputs registered, updating on the edge that samples the valid bit.
// Backpressure: none; one bit accepted on every in_valid cycle, idle cycles freeze all state.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/in_bit serial input bit and its qualifier
//   locked          high while in LOCK
//   state           HUNT=0, CONFIRM=1, LOCK=2
//   err_pulse       one-cycle pulse per mismatch seen in LOCK
//   err_count       saturating mismatch count; present only when
//                   PRBS_CHECKER_ERRCNT_EN is defined, otherwise tied to 0
module prbs_checker #(
    parameter int CONFIRM_LEN = 8,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             locked,
    output logic [1:0]       state,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCK    = 2'd2
    } state_t;

    // Counter terminal values: the counters hold "runs so far", so the
    // transition fires on the bit that would bring them to the parameter.
    localparam logic [7:0] CONF_LAST = 8'(CONFIRM_LEN - 1);
    localparam logic [7:0] LOSS_LAST = 8'(LOSS_THRESH - 1);

    state_t     st;
    logic [7:0] s;
    logic [3:0] fill;
    logic [7:0] good_cnt;
    logic [7:0] bad_cnt;

    logic       pred;
    logic       mismatch;
    logic [7:0] s_rx;

    assign pred     = s[7] ^ s[5] ^ s[4] ^ s[3];
    assign mismatch = in_bit ^ pred;
    assign s_rx     = {s[6:0], in_bit};
    assign state    = st;

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= HUNT;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            s         <= 8'd0;
            fill      <= 4'd0;
            good_cnt  <= 8'd0;
            bad_cnt   <= 8'd0;
        end else begin
            err_pulse <= 1'b0;
            if (in_valid) begin
                case (st)
                    HUNT: begin
                        s <= s_rx;
                        // fill counts bits already held; this is the 8th bit
                        if (fill == 4'd7) begin
                            fill <= 4'd0;
                            // all-zero is the generator's lock-up state
                            if (s_rx != 8'd0) begin
                                st       <= CONFIRM;
                                good_cnt <= 8'd0;
                            end
                        end else begin
                            fill <= fill + 4'd1;
                        end
                    end
                    CONFIRM: begin
                        s <= s_rx;
                        if (!mismatch) begin
                            good_cnt <= good_cnt + 8'd1;
                            if (good_cnt == CONF_LAST) begin
                                st      <= LOCK;
                                locked  <= 1'b1;
                                bad_cnt <= 8'd0;
                            end
                        end else begin
                            st   <= HUNT;
                            fill <= 4'd0;
                        end
                    end
                    LOCK: begin
                        // Free-run on the prediction so received errors never
                        // corrupt the reference: one flipped bit, one error.
                        s <= {s[6:0], pred};
                        if (mismatch) begin
                            err_pulse <= 1'b1;
                            if (bad_cnt == LOSS_LAST) begin
                                st      <= HUNT;
                                locked  <= 1'b0;
                                fill    <= 4'd0;
                                bad_cnt <= 8'd0;
                            end else begin
                                bad_cnt <= bad_cnt + 8'd1;
                            end
                        end else begin
                            bad_cnt <= 8'd0;
                        end
                    end
                    default: begin
                        st     <= HUNT;
                        locked <= 1'b0;
                        fill   <= 4'd0;
                    end
                endcase
            end
        end
    end

`ifdef PRBS_CHECKER_ERRCNT_EN
    logic             lock_err;
    logic [CNT_W-1:0] err_cnt_q;

    assign lock_err = in_valid && (st == LOCK) && mismatch;

    // Saturates at all-ones; cleared only by reset, survives relock.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (lock_err && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
module tb_prbs_checker;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_bit;
    logic       locked;
    logic [1:0] state;
    logic       err_pulse;
    logic [15:0] err_count;
    logic       locked4;
    logic [1:0] state4;
    logic       err_pulse4;
    logic [3:0] err_count4;

    int checks = 0;
    int errors = 0;
    int nerr   = 0;   // mismatches injected while locked since last reset
    int npulse = 0;   // err_pulse cycles observed since last clear
    logic [7:0] g;    // generator model state

    prbs_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .locked(locked), .state(state), .err_pulse(err_pulse), .err_count(err_count)
    );

    prbs_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .locked(locked4), .state(state4), .err_pulse(err_pulse4), .err_count(err_count4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n, input int w);
        int mx;
        int r;
        mx = (1 << w) - 1;
        r  = (n > mx) ? mx : n;
`ifndef PRBS_CHECKER_ERRCNT_EN
        r = 0;
`endif
        return 32'(r);
    endfunction

    task automatic next_bit(output logic b);
        b = g[7];
        g = {g[6:0], g[7] ^ g[5] ^ g[4] ^ g[3]};
    endtask

    task automatic send(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        @(posedge clk);
        #1;
        npulse += int'(err_pulse);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            in_bit = 1'($urandom);
            @(posedge clk);
            #1;
            npulse += int'(err_pulse);
        end
    endtask

    task automatic gsend();
        logic b;
        next_bit(b);
        send(b);
    endtask

    task automatic gflip();
        logic b;
        next_bit(b);
        send(~b);
        nerr++;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; g = 8'hB8;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_pulse", 32'(err_pulse), 32'd0);
        check("rst_count", 32'(err_count), 32'd0);
        rst = 1'b0;

        // Clean acquisition
        for (int i = 1; i <= 16; i++) begin
            gsend();
            if (i == 7)  check("hunt_b7", 32'(state), 32'd0);
            if (i == 8)  check("confirm_b8", 32'(state), 32'd1);
            if (i == 15) check("unlocked_b15", 32'(locked), 32'd0);
        end
        check("locked_b16", 32'(locked), 32'd1);
        check("lock_state_b16", 32'(state), 32'd2);
        repeat (984) gsend();
        check("clean_pulses", 32'(npulse), 32'd0);
        check("clean_count", 32'(err_count), 32'd0);
        check("clean_locked", 32'(locked), 32'd1);

        // Single flipped bit
        gflip();
        check("single_pulse", 32'(err_pulse), 32'd1);
        check("single_count", 32'(err_count), exp_cnt(nerr, 16));
        check("single_locked", 32'(locked), 32'd1);
        idle(1);
        check("pulse_idle_low", 32'(err_pulse), 32'd0);
        gsend();
        check("pulse_next_low", 32'(err_pulse), 32'd0);
        repeat (50) gsend();
        check("single_total_pulses", 32'(npulse), 32'd1);
        check("single_count_hold", 32'(err_count), exp_cnt(nerr, 16));

        // Four consecutive bad bits drop lock on the fourth
        for (int i = 1; i <= 4; i++) begin
            gflip();
            check("burst_pulse", 32'(err_pulse), 32'd1);
            if (i < 4) check("burst_locked", 32'(locked), 32'd1);
        end
        check("loss_locked", 32'(locked), 32'd0);
        check("loss_state", 32'(state), 32'd0);
        check("loss_count", 32'(err_count), exp_cnt(nerr, 16));
        for (int i = 1; i <= 16; i++) begin
            gsend();
            if (i == 15) check("relock_b15", 32'(locked), 32'd0);
        end
        check("relock_b16", 32'(locked), 32'd1);
        check("relock_count", 32'(err_count), exp_cnt(nerr, 16));
        check("relock_count4", 32'(err_count4), exp_cnt(nerr, 4));

        // Isolated errors past 15 saturate the narrow counter without losing lock
        for (int i = 0; i < 20; i++) begin
            gflip();
            gsend();
        end
        check("sat_locked", 32'(locked), 32'd1);
        check("sat_count16", 32'(err_count), exp_cnt(nerr, 16));
        check("sat_count4", 32'(err_count4), exp_cnt(nerr, 4));
        check("sat_pulses", 32'(npulse), 32'(nerr));

        // Reset while locked
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_locked", 32'(locked), 32'd0);
        check("midrst_count", 32'(err_count), 32'd0);
        check("midrst_count4", 32'(err_count4), 32'd0);
        rst = 1'b0; nerr = 0; npulse = 0;

        // All-zero fill rejected, then fresh acquisition
        repeat (8) send(1'b0);
        check("zero_fill_hunt", 32'(state), 32'd0);
        g = 8'hB8;
        for (int i = 1; i <= 16; i++) begin
            gsend();
            if (i == 8)  check("zf_confirm_b8", 32'(state), 32'd1);
            if (i == 15) check("zf_unlocked_b15", 32'(locked), 32'd0);
        end
        check("zf_locked_b16", 32'(locked), 32'd1);

        // Random valid gaps
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; g = 8'hB8; npulse = 0;
        for (int i = 1; i <= 16; i++) begin
            idle(int'($urandom_range(1, 5)));
            gsend();
            if (i == 8)  check("gap_confirm_b8", 32'(state), 32'd1);
            if (i == 15) check("gap_unlocked_b15", 32'(locked), 32'd0);
        end
        check("gap_locked_b16", 32'(locked), 32'd1);
        for (int i = 0; i < 200; i++) begin
            idle(int'($urandom_range(1, 5)));
            gsend();
        end
        idle(3);
        check("gap_state_idle", 32'(state), 32'd2);
        check("gap_pulses", 32'(npulse), 32'd0);
        check("gap_count", 32'(err_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial receive-side checker for the 8-bit pseudo-random sequence produced by the game's LFSR generator, which uses polynomial feedback `r7^r5^r4^r3`, shifts left and inserts the feedback bit at bit 0. It samples one bit per valid cycle, self-synchronises to the sequence and confirms lock. Once locked, it flags and counts bit errors, and drops lock after repeated mismatches. It sits at the consuming end of any link or self-test path that carries the generator's bit stream.

## Interface
- `CONFIRM_LEN`, default 8: consecutive correct predictions required in CONFIRM before declaring lock (1..255).
- `LOSS_THRESH`, default 4: consecutive mismatches in LOCK that force a return to HUNT (1..255).
- `CNT_W`, default 16: width of the error counter.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: `in_bit` is sampled on this cycle.
- `in_bit` input 1: received serial bit, in generator emission order.
- `locked` output 1: high while the FSM is in LOCK.
- `state` output 2: FSM state; HUNT=0, CONFIRM=1, LOCK=2.
- `err_pulse` output 1: one-cycle pulse on each mismatch seen in LOCK.
- `err_count` output CNT_W: saturating count of mismatches seen in LOCK.

## Operation
- Internal 8-bit shift register `s`, shifted left, with the new bit entering `s[0]`. Prediction `p = s[7]^s[5]^s[4]^s[3]`.
- Nothing changes on cycles where `in_valid`=0, except that `err_pulse` is 0.
- HUNT:
  - Each valid bit shifts `in_bit` into `s` and increments a fill counter (0..8).
  - When the 8th bit is shifted in, the checker tests the resulting `s`:
    - Nonzero: go to CONFIRM with the good-run counter cleared.
    - Zero: stay in HUNT and restart the fill counter. The all-zero state is a lock-up state of the generator and is never accepted.
- CONFIRM:
  - Each valid bit is compared with `p`, and `in_bit` is shifted into `s`.
  - Match: increment the good-run counter. When it reaches CONFIRM_LEN, go to LOCK with the bad-run counter cleared.
  - Mismatch: go to HUNT with the fill counter at 0. Mismatches in CONFIRM are not counted and produce no `err_pulse`.
- LOCK:
  - Each valid bit shifts `p` into `s`, not `in_bit`. The reference sequence is therefore immune to received errors, and an isolated flipped bit yields exactly one error.
  - Match: clear the bad-run counter.
  - Mismatch:
    - Assert `err_pulse`.
    - Increment `err_count`; it saturates at 2^CNT_W−1 and never wraps.
    - Increment the bad-run counter. When it reaches LOSS_THRESH, go to HUNT with the fill counter at 0.
- `err_count` is cleared only by `rst`. It persists across loss of lock and relock.
- Reset values: `state`=HUNT, `locked`=0, `err_pulse`=0, `err_count`=0, `s`=0, and all internal counters 0. Reset mid-stream discards any partial fill or lock immediately.

## Timing
- All outputs are registered and update on the clock edge that samples the triggering valid bit.
- Lock latency from reset with continuous valid error-free data: `locked` rises on the edge sampling valid bit number 8+CONFIRM_LEN.
- `err_pulse` is high for exactly the one cycle after the edge that sampled the bad bit. `err_count` updates on that same edge.
- Lock loss: `locked` falls on the edge that samples the LOSS_THRESH-th consecutive bad bit. That bit still pulses `err_pulse` and is still counted.
- Gaps in `in_valid` of any length do not affect prediction or counters.

## Configuration
- `PRBS_CHECKER_ERRCNT_EN` defined: `err_count` is implemented as described above.
- `PRBS_CHECKER_ERRCNT_EN` undefined: no counter flops exist and `err_count` is tied to 0. `err_pulse`, `locked`, `state` and lock-loss behaviour are unchanged.

## Test plan
Generator seed is 0xB8; the stream begins 1,0,1,1,1,0,0,0,0,0,0,1,1,…

- Reset, then feed the generator stream continuously with `in_valid`=1 → `state`=CONFIRM after bit 8, `locked`=1 after bit 16 (defaults), `err_count` stays 0 for 1000 bits.
- Locked, invert one bit → exactly one `err_pulse`, `err_count`=1, `locked` stays 1, and no further errors follow.
- Locked, invert 4 consecutive bits → 4 pulses, `err_count`=4, `locked`=0 on the 4th bad bit; with a clean stream afterwards, relock 16 valid bits later and `err_count` stays 4.
- Feed 8 zeros after reset, then the generator stream → the zero fill is rejected (`state` stays HUNT), then lock 16 bits after the first nonzero fill.
- Insert random `in_valid`=0 gaps of 1–5 cycles into the clean stream → same lock point counted in valid bits, and zero errors.
- With CNT_W=4, force more than 15 errors while locked → `err_count` saturates at 15. With the macro undefined, `err_count` stays 0 while `err_pulse` still fires.
